// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding for the countdown timer
package timer_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_PAUSED = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        RUN    = ST_RUN,
        PAUSED = ST_PAUSED,
        DONE   = ST_DONE
    } timer_state_t;

endpackage

// File: rtl/down_counter_N_bits.sv
// rtl/down_counter_N_bits.sv - N-bit loadable down counter with terminal-count compares
module down_counter_N_bits #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_en,
    input  logic [N-1:0] load_data,
    input  logic         dec_en,
    output logic [N-1:0] count_q,
    output logic         is_one,
    output logic         is_zero
);

    localparam logic [N-1:0] ONE = N'(1);

    // The zero guard keeps the count from wrapping even if a decrement slips through at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_en) begin
            count_q <= load_data;
        end else if (dec_en && !is_zero) begin
            count_q <= count_q - ONE;
        end
    end

    assign is_one  = (count_q == ONE);
    assign is_zero = (count_q == '0);

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - tick-driven countdown timer with one-shot or periodic expiry
module countdown_timer
    import timer_pkg::*;
#(
    parameter int N           = 8,
    parameter int AUTO_RELOAD = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic         load,
    input  logic [N-1:0] load_value,
    input  logic         start,
    input  logic         pause,
    output logic [N-1:0] count_q,
    output logic         running,
    output logic         expired,
    output logic         done
);

    timer_state_t state_q;
    timer_state_t state_d;

    logic [N-1:0] reload_q;
    logic         reload_we;
    logic         cnt_load;
    logic [N-1:0] cnt_data;
    logic         cnt_dec;
    logic         cnt_is_one;
    logic         cnt_is_zero;
    logic         done_d;

    down_counter_N_bits #(.N(N)) u_counter (
        .clk       (clk),
        .reset     (reset),
        .load_en   (cnt_load),
        .load_data (cnt_data),
        .dec_en    (cnt_dec),
        .count_q   (count_q),
        .is_one    (cnt_is_one),
        .is_zero   (cnt_is_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= done_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reload_q <= '0;
        end else if (reload_we) begin
            reload_q <= load_value;
        end
    end

    // Input priority is load > pause > start > tick; tick only counts once already in RUN.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !cnt_is_zero) state_d = RUN;
                end
                RUN: begin
                    if (pause) begin
                        state_d = PAUSED;
                    end else if (tick && cnt_is_one && (AUTO_RELOAD == 0)) begin
                        state_d = DONE;
                    end
                end
                PAUSED: begin
                    if (start) state_d = RUN;
                end
                DONE: begin
                    if (start && (reload_q != '0)) state_d = RUN;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        reload_we = 1'b0;
        cnt_load  = 1'b0;
        cnt_data  = load_value;
        cnt_dec   = 1'b0;
        done_d    = 1'b0;
        if (load) begin
            reload_we = 1'b1;
            cnt_load  = 1'b1;
            cnt_data  = load_value;
        end else begin
            case (state_q)
                RUN: begin
                    if (!pause && tick) begin
                        if (cnt_is_one) begin
                            done_d = 1'b1;
                            if (AUTO_RELOAD != 0) begin
                                cnt_load = 1'b1;
                                cnt_data = reload_q;
                            end else begin
                                cnt_dec = 1'b1;
                            end
                        end else begin
                            cnt_dec = 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        cnt_load = 1'b1;
                        cnt_data = reload_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign running = (state_q == RUN);
    assign expired = (state_q == DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - scoreboard bench for countdown_timer in one-shot and periodic modes
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       load;
    logic [7:0] load_value;
    logic       start;
    logic       pause;

    logic [7:0] cnt_os, cnt_ar;
    logic       run_os, run_ar;
    logic       exp_os, exp_ar;
    logic       done_os, done_ar;

    always #5 clk = ~clk;

    countdown_timer #(.N(8), .AUTO_RELOAD(0)) dut_os (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .pause      (pause),
        .count_q    (cnt_os),
        .running    (run_os),
        .expired    (exp_os),
        .done       (done_os)
    );

    countdown_timer #(.N(8), .AUTO_RELOAD(1)) dut_ar (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .pause      (pause),
        .count_q    (cnt_ar),
        .running    (run_ar),
        .expired    (exp_ar),
        .done       (done_ar)
    );

    typedef struct {
        bit         sel;
        logic [7:0] cnt;
        logic       run;
        logic       dn;
        logic       ex;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    event sample_ev;
    int   n_checks = 0;
    int   n_fail   = 0;

    always begin
        @(sample_ev);
        while (exp_q.size() > 0) begin
            exp_t       e;
            logic [10:0] act;
            logic [10:0] req;
            e = exp_q.pop_front();
            if (e.sel) act = {cnt_ar, run_ar, done_ar, exp_ar};
            else       act = {cnt_os, run_os, done_os, exp_os};
            req = {e.cnt, e.run, e.dn, e.ex};
            n_checks++;
            if (act !== req) begin
                n_fail++;
                $display("FAIL %s (%s): got cnt=%0d run=%b done=%b exp=%b, want cnt=%0d run=%b done=%b exp=%b",
                         e.name, e.sel ? "periodic" : "oneshot",
                         act[10:3], act[2], act[1], act[0],
                         req[10:3], req[2], req[1], req[0]);
            end
        end
    end

    task automatic push_exp(input bit s, input logic [7:0] ec, input logic er, input logic ed,
                            input logic ee, input string nm);
        exp_t e;
        e.sel  = s;
        e.cnt  = ec;
        e.run  = er;
        e.dn   = ed;
        e.ex   = ee;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit s, input logic tk, input logic ld, input logic [7:0] lv,
                        input logic st, input logic ps, input logic [7:0] ec,
                        input logic er, input logic ed, input logic ee, input string nm);
        @(negedge clk);
        tick       = tk;
        load       = ld;
        load_value = lv;
        start      = st;
        pause      = ps;
        @(posedge clk);
        #1;
        push_exp(s, ec, er, ed, ee, nm);
        ->sample_ev;
    endtask

    initial begin
        reset      = 1'b1;
        tick       = 1'b0;
        load       = 1'b0;
        load_value = 8'd0;
        start      = 1'b0;
        pause      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push_exp(0, 8'd0, 0, 0, 0, "reset_os");
        push_exp(1, 8'd0, 0, 0, 0, "reset_ar");
        ->sample_ev;
        @(negedge clk);
        reset = 1'b0;

        // one-shot countdown from 5, ticks 3 cycles apart
        step(0, 0, 1, 8'd5, 0, 0, 8'd5, 0, 0, 0, "t1_load");
        step(0, 0, 0, 8'd0, 1, 0, 8'd5, 1, 0, 0, "t1_start");
        for (int k = 4; k >= 0; k--) begin
            step(0, 1, 0, 8'd0, 0, 0, 8'(k), k != 0, k == 0, k == 0, "t1_tick");
            if (k != 0) repeat (2) step(0, 0, 0, 8'd0, 0, 0, 8'(k), 1, 0, 0, "t1_gap");
        end
        step(0, 0, 0, 8'd0, 0, 0, 8'd0, 0, 0, 1, "t1_after");

        // pause with coincident tick, ticks ignored while paused, resume
        step(0, 0, 1, 8'd3, 0, 0, 8'd3, 0, 0, 0, "t2_load");
        step(0, 0, 0, 8'd0, 1, 0, 8'd3, 1, 0, 0, "t2_start");
        step(0, 1, 0, 8'd0, 0, 0, 8'd2, 1, 0, 0, "t2_tick");
        step(0, 1, 0, 8'd0, 0, 1, 8'd2, 0, 0, 0, "t2_pause_tick");
        repeat (4) step(0, 1, 0, 8'd0, 0, 0, 8'd2, 0, 0, 0, "t2_paused_tick");
        step(0, 0, 0, 8'd0, 1, 0, 8'd2, 1, 0, 0, "t2_resume");
        step(0, 1, 0, 8'd0, 0, 0, 8'd1, 1, 0, 0, "t2_tick1");
        step(0, 1, 0, 8'd0, 0, 0, 8'd0, 0, 1, 1, "t2_tick0");

        // periodic reload of 2 with tick held high
        step(1, 0, 1, 8'd2, 0, 0, 8'd2, 0, 0, 0, "t3_load");
        step(1, 0, 0, 8'd0, 1, 0, 8'd2, 1, 0, 0, "t3_start");
        for (int i = 1; i <= 6; i++)
            step(1, 1, 0, 8'd0, 0, 0, (i % 2) ? 8'd1 : 8'd2, 1, (i % 2) == 0, 0, "t3_tick");
        step(1, 0, 1, 8'd1, 0, 0, 8'd1, 0, 0, 0, "t3_load1");
        step(1, 0, 0, 8'd0, 1, 0, 8'd1, 1, 0, 0, "t3_start1");
        repeat (3) step(1, 1, 0, 8'd0, 0, 0, 8'd1, 1, 1, 0, "t3_every_tick");

        // simultaneous events
        step(0, 0, 1, 8'd9, 0, 0, 8'd9, 0, 0, 0, "t4_load9");
        step(0, 0, 0, 8'd0, 1, 0, 8'd9, 1, 0, 0, "t4_start");
        step(0, 1, 0, 8'd0, 0, 0, 8'd8, 1, 0, 0, "t4_tick");
        step(0, 1, 1, 8'd7, 0, 1, 8'd7, 0, 0, 0, "t4_load_pause_tick");
        step(0, 1, 0, 8'd0, 1, 0, 8'd7, 1, 0, 0, "t4_start_tick_idle");
        step(0, 1, 0, 8'd0, 1, 0, 8'd6, 1, 0, 0, "t4_start_in_run");

        // zero load and restart from DONE
        step(0, 0, 1, 8'd0, 0, 0, 8'd0, 0, 0, 0, "t5_load0");
        step(0, 0, 0, 8'd0, 1, 0, 8'd0, 0, 0, 0, "t5_start0");
        step(0, 0, 1, 8'd1, 0, 0, 8'd1, 0, 0, 0, "t5_load1");
        step(0, 0, 0, 8'd0, 1, 0, 8'd1, 1, 0, 0, "t5_start1");
        step(0, 1, 0, 8'd0, 0, 0, 8'd0, 0, 1, 1, "t5_expire");
        step(0, 0, 0, 8'd0, 1, 0, 8'd1, 1, 0, 0, "t5_done_restart");
        step(0, 1, 0, 8'd0, 0, 0, 8'd0, 0, 1, 1, "t5_expire2");
        step(0, 0, 1, 8'd4, 0, 0, 8'd4, 0, 0, 0, "t5_load4");
        step(0, 0, 0, 8'd0, 1, 0, 8'd4, 1, 0, 0, "t5_start4");

        // asynchronous reset mid-count
        step(0, 0, 1, 8'd5, 0, 0, 8'd5, 0, 0, 0, "t6_load");
        step(0, 0, 0, 8'd0, 1, 0, 8'd5, 1, 0, 0, "t6_start");
        step(0, 1, 0, 8'd0, 0, 0, 8'd4, 1, 0, 0, "t6_tick4");
        step(0, 1, 0, 8'd0, 0, 0, 8'd3, 1, 0, 0, "t6_tick3");
        #2;
        reset = 1'b1;
        #1;
        push_exp(0, 8'd0, 0, 0, 0, "t6_async_os");
        push_exp(1, 8'd0, 0, 0, 0, "t6_async_ar");
        ->sample_ev;
        step(0, 1, 0, 8'd0, 0, 0, 8'd0, 0, 0, 0, "t6_held");
        @(negedge clk);
        reset = 1'b0;
        step(0, 1, 0, 8'd0, 0, 0, 8'd0, 0, 0, 0, "t6_tick_ignored");
        step(0, 1, 0, 8'd0, 1, 0, 8'd0, 0, 0, 0, "t6_start_no_reload");
        step(0, 0, 1, 8'd2, 0, 0, 8'd2, 0, 0, 0, "t6_reload");
        step(0, 0, 0, 8'd0, 1, 0, 8'd2, 1, 0, 0, "t6_restart");
        step(0, 1, 0, 8'd0, 0, 0, 8'd1, 1, 0, 0, "t6_tick1");

        @(negedge clk);
        tick = 1'b0;
        #5;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter that consumes the one-cycle `tick` enable produced by the team's prescaler/divider and counts a programmed number of ticks down to zero. It signals expiry with a one-cycle `done` pulse and, in one-shot mode, a held `expired` level. It sits between the 1 Hz tick source and the user-facing timer/alarm logic, for example display or LED control.

## Interface
- `N`, default 8: width of the count and load value.
- `AUTO_RELOAD`, default 0: 0 selects one-shot mode (stop in DONE); 1 selects periodic mode (reload and keep running).

- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `tick`  in  1  one-cycle count enable from the prescaler; sampled only in RUN.
- `load`  in  1  loads `load_value` into the count and the reload register.
- `load_value`  in  N  value captured on `load`.
- `start`  in  1  start or resume counting.
- `pause`  in  1  freeze counting.
- `count_q`  out  N  current remaining count (registered).
- `running`  out  1  high while state is RUN.
- `done`  out  1  one-cycle pulse on expiry.
- `expired`  out  1  high while state is DONE.

## Operation
- States: IDLE, RUN, PAUSED, DONE.
- Reset forces state to IDLE. All of the following are 0: `count_q`, the reload register, `running`, `done` and `expired`.
- Priority each cycle is `load` > `pause` > `start` > `tick`.
- `load` (any state):
  - `count_q` and the reload register take `load_value`.
  - State goes to IDLE; `done` is 0 that cycle.
- IDLE:
  - `start` with `count_q` != 0 goes to RUN.
  - `start` with `count_q` == 0 is ignored (stays IDLE).
- RUN:
  - `pause` goes to PAUSED, and any `tick` in the same cycle is ignored.
  - `tick` with `count_q` > 1: `count_q` decrements by 1.
  - `tick` with `count_q` == 1, one-shot mode: `count_q` becomes 0, state goes to DONE, `done` pulses.
  - `tick` with `count_q` == 1, periodic mode: `count_q` takes the reload register value, state stays RUN, `done` pulses.
  - `start` has no effect.
- PAUSED:
  - `start` goes to RUN.
  - `tick` and `pause` are ignored; `count_q` holds.
- DONE:
  - `count_q` holds 0 and `expired` = 1.
  - `start` reloads `count_q` from the reload register. It goes to RUN if that value is != 0, otherwise it stays DONE.
- Arithmetic:
  - Decrement is unsigned N-bit.
  - `count_q` never wraps below 0, because the 1→0 step is the terminal case.
  - Periodic mode with reload value 1 gives a `done` pulse on every tick.
- `running` and `expired` are decoded from the state register, so they are glitch-free.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- `tick` is sampled in the cycle it is high and only if the state is already RUN. A `tick` in the same cycle as `start` is ignored.
- `count_q` update: visible one cycle after the sampled `tick` or `load`.
- `done`: high for exactly one cycle, in the first cycle `count_q` shows 0 (one-shot) or the reload value (periodic).
- State change: visible one cycle after the causing input.
- Reset mid-count:
  - Takes effect immediately (asynchronous), with no `done` pulse.
  - The reload value is lost and must be reloaded.
- `tick` held high for several cycles decrements once per cycle. The block does not edge-detect.

## Structure
- Package `timer_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} timer_state_t`.
  - Localparams for the state encoding.
- Sub-module `down_counter_N_bits` contains the N-bit register with load mux, decrement and `is_one` compare. It is reused by the FSM for `count_q`.
- The FSM and the reload register live in `countdown_timer`.

## Test plan
- Reset then `load`=5, `start`, 5 ticks spaced 3 cycles apart:
  - `count_q` goes 5,4,3,2,1,0.
  - `done` is a one-cycle pulse when `count_q` = 0.
  - `expired` = 1 and `running` = 0 afterwards.
- One-shot, `load`=3, `start`, one tick, then `pause` together with a tick:
  - `count_q` stays 2 through 4 further ticks.
  - `start` resumes; 2 ticks give 0 and `done`.
- `AUTO_RELOAD`=1, `load`=2, `start`, 6 ticks:
  - `count_q` goes 1,2,1,2,1,2.
  - 3 `done` pulses; `running` stays 1.
- Simultaneous events:
  - `load`=7 together with `pause` and `tick` in RUN gives `count_q`=7, state IDLE.
  - `start` together with `tick` in IDLE gives RUN with `count_q` unchanged.
- Zero and restart:
  - `load`=0 then `start` stays IDLE.
  - In DONE after `load`=4, `start` gives `count_q`=4 and RUN.
- Asynchronous `reset` asserted mid-RUN at `count_q`=3, between clock edges:
  - All outputs go to 0 immediately.
  - No `done` pulse; later ticks are ignored until `load`/`start`.
